// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: debounce states,
// scan-result encoding and column decode functions.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_t;

  // code is meaningful only when kind is RES_SINGLE
  typedef struct packed {
    res_kind_t  kind;
    logic [3:0] code;
  } scan_res_t;

  function automatic logic [2:0] low_count(input logic [COLS-1:0] c);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + {2'b00, ~c[i]};
    return n;
  endfunction

  function automatic logic [1:0] low_index(input logic [COLS-1:0] c);
    logic [1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) if (!c[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Press-event handshake between the keypad scanner and its consumer.
// An event transfers on a rising clk edge where ev_valid && ev_ready; ev_code
// is stable while ev_valid is high, and ev_valid never drops without a transfer.
interface keypad_scan_if;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic       ev_ready;

  modport master (output ev_valid, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/keypad_debounce.sv
// Debounce FSM over whole-scan results plus the one-deep press-event register
// with sticky overflow.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 res_valid,
  input  scan_res_t            res,
  output logic                 key_down,
  output logic [3:0]           key_code,
  keypad_scan_if.master        ev,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output kp_state_t            dbg_state
);

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  kp_state_t  state;
  logic [3:0] cnt;
  logic [3:0] cand;
  logic [3:0] cnt_inc;
  logic       single;
  logic       push;

  assign dbg_state = state;

  always_comb begin
    cnt_inc = cnt + 4'd1;
    single  = res_valid && (res.kind == RES_SINGLE);
    push    = 1'b0;
    // a push happens exactly on the transitions into PRESSED that start a new press
    if (single) begin
      if (state == ST_RELEASED && DS == 4'd1) push = 1'b1;
      if (state == ST_PRESS_CHK && res.code == cand && cnt_inc >= DS) push = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RELEASED;
      cnt      <= '0;
      cand     <= '0;
      key_down <= 1'b0;
      key_code <= '0;
    end else if (res_valid) begin
      unique case (state)
        ST_RELEASED: begin
          if (single) begin
            cand <= res.code;
            if (DS == 4'd1) begin
              state    <= ST_PRESSED;
              key_down <= 1'b1;
              key_code <= res.code;
              cnt      <= '0;
            end else begin
              state <= ST_PRESS_CHK;
              cnt   <= 4'd1;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (!single) begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end else if (res.code != cand) begin
            cand <= res.code;
            cnt  <= 4'd1;
          end else if (cnt_inc >= DS) begin
            state    <= ST_PRESSED;
            key_down <= 1'b1;
            key_code <= cand;
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!(single && res.code == key_code)) begin
            if (DS == 4'd1) begin
              state    <= ST_RELEASED;
              key_down <= 1'b0;
              cnt      <= '0;
            end else begin
              state <= ST_RELEASE_CHK;
              cnt   <= 4'd1;
            end
          end
        end
        ST_RELEASE_CHK: begin
          if (single && res.code == key_code) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt_inc >= DS) begin
            state    <= ST_RELEASED;
            key_down <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= ST_RELEASED;
      endcase
    end
  end

  // A push into a full, unaccepted register is dropped and flagged; a drop
  // beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev.ev_valid <= 1'b0;
      ev.ev_code  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) begin
        if (!ev.ev_valid || ev.ev_ready) begin
          ev.ev_valid <= 1'b1;
          ev.ev_code  <= res.code;
        end
      end else if (ev.ev_valid && ev.ev_ready) begin
        ev.ev_valid <= 1'b0;
      end

      if (push && ev.ev_valid && !ev.ev_ready) overflow <= 1'b1;
      else if (ovf_clr)                        overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: walks one active-low row at a time, samples the
// synchronized columns at the end of each dwell and classifies each full scan.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ROWS-1:0] row,
  input  logic [COLS-1:0] col_in,
  output logic            key_down,
  output logic [3:0]      key_code,
  keypad_scan_if.master   ev,
  output logic            overflow,
  input  logic            ovf_clr,
  output kp_state_t       dbg_state
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [COLS-1:0]  col_s1, col_s2;
  logic [DIV_W-1:0] dwell;
  logic [1:0]       row_idx;
  logic             dwell_last;

  // running summary of the scan in progress: 0, 1 or "2+" keys seen
  logic [1:0]       hit_cnt, hit_cnt_nx;
  logic [3:0]       hit_code, hit_code_nx;
  logic [2:0]       row_lows, hit_sum;

  logic             res_valid;
  scan_res_t        res_q;

  assign row        = ~(4'b0001 << row_idx);
  assign dwell_last = (dwell == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  always_comb begin
    row_lows    = low_count(col_s2);
    hit_sum     = {1'b0, hit_cnt} + row_lows;
    hit_cnt_nx  = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
    hit_code_nx = hit_code;
    if (hit_cnt == 2'd0 && row_lows == 3'd1) hit_code_nx = {row_idx, low_index(col_s2)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell     <= '0;
      row_idx   <= '0;
      hit_cnt   <= '0;
      hit_code  <= '0;
      res_valid <= 1'b0;
      res_q     <= '{kind: RES_NONE, code: 4'd0};
    end else begin
      res_valid <= 1'b0;
      if (dwell_last) begin
        dwell   <= '0;
        row_idx <= row_idx + 2'd1;
        if (row_idx == 2'(ROWS - 1)) begin
          res_valid  <= 1'b1;
          res_q.code <= hit_code_nx;
          unique case (hit_cnt_nx)
            2'd0:    res_q.kind <= RES_NONE;
            2'd1:    res_q.kind <= RES_SINGLE;
            default: res_q.kind <= RES_MULTI;
          endcase
          hit_cnt  <= '0;
          hit_code <= '0;
        end else begin
          hit_cnt  <= hit_cnt_nx;
          hit_code <= hit_code_nx;
        end
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res       (res_q),
    .key_down  (key_down),
    .key_code  (key_code),
    .ev        (ev),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .dbg_state (dbg_state)
  );

endmodule
